// File: rtl/lcd_pkg.sv
// lcd_pkg: definitions shared by the LCD command sequencer and its users.
//   - opcode constants understood by the LCD image controller
//   - state encoding of the command sequencer
//   - bit positions inside a command-ROM word ([3] valid, [2:0] opcode)
//   - rom_decode(): turns a ROM word into the opcode to issue
package lcd_pkg;

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_AVG   = 3'd5;
  localparam logic [2:0] CMD_MIRX  = 3'd6;
  localparam logic [2:0] CMD_MIRY  = 3'd7;

  localparam int ROM_VALID_BIT = 3;
  localparam int ROM_OP_MSB    = 2;
  localparam int ROM_OP_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_IDLE,
    ST_WAIT_DONE,
    ST_FINISH
  } state_e;

  // An end marker (valid bit clear) is turned into a write so that every
  // run is terminated by exactly one write.
  function automatic logic [2:0] rom_decode(input logic [3:0] word);
    return word[ROM_VALID_BIT] ? word[ROM_OP_MSB:ROM_OP_LSB] : CMD_WRITE;
  endfunction

endpackage

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: plays a command script from an external command ROM onto the
// LCD controller's cmd/cmd_valid/busy handshake, guarantees that a write ends
// the run and raises finish once the controller reports done.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   crom_en/crom_a  command-ROM read enable / address
//   crom_q          ROM word, valid one cycle after crom_en
//   lcd_busy        controller busy (high while loading and while executing)
//   lcd_done        controller done, sticky
//   cmd/cmd_valid   opcode and one-cycle strobe to the controller
//   cmd_cnt         number of commands issued
//   finish          run complete, sticky until reset
//   err             (CMD_SEQ_WDT_EN only) watchdog expired, sticky
//
// Optional feature macro: CMD_SEQ_WDT_EN adds a watchdog on the wait states
// which forces FINISH with err=1 after TIMEOUT cycles in one wait state.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic              crom_en,
  output logic [ADDR_W-1:0] crom_a,
  input  logic [3:0]        crom_q,
  input  logic              lcd_busy,
  input  logic              lcd_done,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  output logic [ADDR_W:0]   cmd_cnt,
  output logic              finish
`ifdef CMD_SEQ_WDT_EN
  ,
  output logic              err
`endif
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("lcd_cmd_seq: TIMEOUT must be at least 1");
  end

  state_e            state_q, state_d;
  logic              fetch_ph_q, fetch_ph_d;  // 0: ROM read cycle, 1: latch cycle
  logic [ADDR_W-1:0] crom_a_q, crom_a_d;
  logic [2:0]        cmd_r_q, cmd_r_d;        // opcode pending issue
  logic [2:0]        cmd_q, cmd_d;            // last opcode strobed out
  logic [ADDR_W:0]   cmd_cnt_q, cmd_cnt_d;

`ifdef CMD_SEQ_WDT_EN
  localparam int WDT_W = $clog2(TIMEOUT + 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_ph_q <= 1'b0;
      crom_a_q   <= '0;
      cmd_r_q    <= CMD_WRITE;
      cmd_q      <= CMD_WRITE;
      cmd_cnt_q  <= '0;
`ifdef CMD_SEQ_WDT_EN
      wdt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_ph_q <= fetch_ph_d;
      crom_a_q   <= crom_a_d;
      cmd_r_q    <= cmd_r_d;
      cmd_q      <= cmd_d;
      cmd_cnt_q  <= cmd_cnt_d;
`ifdef CMD_SEQ_WDT_EN
      wdt_q      <= wdt_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_ph_d = 1'b0;
    crom_a_d   = crom_a_q;
    cmd_r_d    = cmd_r_q;
    cmd_d      = cmd_q;
    cmd_cnt_d  = cmd_cnt_q;
    crom_en    = 1'b0;
    cmd_valid  = 1'b0;
`ifdef CMD_SEQ_WDT_EN
    err_d      = err_q;
    wdt_d      = wdt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!lcd_busy) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!fetch_ph_q) begin
          crom_en    = 1'b1;
          fetch_ph_d = 1'b1;
        end else begin
          cmd_r_d = rom_decode(crom_q);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Strobe is combinational on busy so it can never coincide with it.
        if (!lcd_busy) begin
          cmd_valid = 1'b1;
          cmd_d     = cmd_r_q;
          cmd_cnt_d = cmd_cnt_q + 1'b1;
          state_d   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (lcd_busy) state_d = (cmd_r_q == CMD_WRITE) ? ST_WAIT_DONE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (!lcd_busy) begin
          if (crom_a_q == '1) begin
            // Script exhausted without a write: append a synthetic one
            // rather than wrapping the address.
            cmd_r_d = CMD_WRITE;
            state_d = ST_ISSUE;
          end else begin
            crom_a_d = crom_a_q + 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (lcd_done) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_FINISH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef CMD_SEQ_WDT_EN
    // Counter restarts on every state change; the transition fires on the
    // edge where it would reach TIMEOUT.
    if (state_d != state_q) begin
      wdt_d = '0;
    end else if (state_q != ST_FINISH) begin
      wdt_d = wdt_q + 1'b1;
      if ((state_q == ST_WAIT_ACK || state_q == ST_WAIT_IDLE || state_q == ST_WAIT_DONE) &&
          (wdt_q == WDT_W'(TIMEOUT - 1))) begin
        err_d   = 1'b1;
        state_d = ST_FINISH;
        wdt_d   = '0;
      end
    end
`endif
  end

  assign crom_a  = crom_a_q;
  assign cmd     = cmd_valid ? cmd_r_q : cmd_q;
  assign cmd_cnt = cmd_cnt_q;
  assign finish  = (state_q == ST_FINISH);
`ifdef CMD_SEQ_WDT_EN
  assign err     = err_q;
`endif

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb_lcd_cmd_seq: directed bench for lcd_cmd_seq with a command-ROM model and
// a simple LCD controller model (busy for 'hold' cycles after each strobe,
// done raised when busy drops after a write).
module tb_lcd_cmd_seq;
  import lcd_pkg::*;

`ifdef CMD_SEQ_WDT_EN
  localparam int TB_TIMEOUT = 20;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic       clk, reset;
  logic       crom_en;
  logic [4:0] crom_a;
  logic [3:0] crom_q;
  logic       lcd_busy, lcd_done;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [5:0] cmd_cnt;
  logic       finish;
`ifdef CMD_SEQ_WDT_EN
  logic       err;
`endif

  lcd_cmd_seq #(.ADDR_W(5), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .crom_en   (crom_en),
    .crom_a    (crom_a),
    .crom_q    (crom_q),
    .lcd_busy  (lcd_busy),
    .lcd_done  (lcd_done),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_cnt   (cmd_cnt),
    .finish    (finish)
`ifdef CMD_SEQ_WDT_EN
    ,
    .err       (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- ROM and controller model ----------------
  logic [3:0] rom [0:31];
  int   hold       = 2;
  int   busy_left  = 0;
  bit   ack_en     = 1;
  bit   write_seen = 0;
  int   cyc        = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    logic       s_valid, s_en;
    logic [2:0] s_cmd;
    logic [4:0] s_a;
    forever begin
      @(negedge clk);
      s_valid = cmd_valid;
      s_cmd   = cmd;
      s_en    = crom_en;
      s_a     = crom_a;
      @(posedge clk);
      #1;
      if (s_en) crom_q = rom[s_a];
      if (s_valid && ack_en) begin
        busy_left = hold;
        if (s_cmd == CMD_WRITE) write_seen = 1;
      end
      if (busy_left > 0) begin
        lcd_busy = 1'b1;
        busy_left--;
      end else begin
        lcd_busy = 1'b0;
        if (write_seen) lcd_done = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [2:0] strobes[$];
  int         strobe_cyc[$];
  int         lat_q[$];
  int         bad_busy, dbl, cmd_glitch, wrap, finish_early;
  int         fall_cyc, finish_cyc, first_fetch;
  logic [31:0] fetch_mask;
  logic       prev_valid, prev_busy;
  logic [4:0] prev_a;
  logic [2:0] last_cmd;

  task automatic clear_mon();
    strobes.delete();
    strobe_cyc.delete();
    lat_q.delete();
    bad_busy = 0; dbl = 0; cmd_glitch = 0; wrap = 0; finish_early = 0;
    fall_cyc = cyc; finish_cyc = -1; first_fetch = -1;
    fetch_mask = '0;
    prev_valid = 1'b0; prev_busy = 1'b1; prev_a = '0; last_cmd = CMD_WRITE;
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (cmd_valid) begin
        strobes.push_back(cmd);
        strobe_cyc.push_back(cyc);
        lat_q.push_back(cyc - fall_cyc);
        if (lcd_busy) bad_busy++;
        if (prev_valid) dbl++;
        last_cmd = cmd;
        $display("[%0t] strobe #%0d cmd=%0d crom_a=%0d cmd_cnt=%0d", $time, strobes.size(), cmd, crom_a, cmd_cnt);
      end else if (cmd !== last_cmd) begin
        cmd_glitch++;
      end
      if (crom_en) begin
        fetch_mask[crom_a] = 1'b1;
        if (first_fetch < 0) first_fetch = int'(crom_a);
      end
      if (prev_a == 5'd31 && crom_a == 5'd0) wrap++;
      if (prev_busy && !lcd_busy) fall_cyc = cyc;
      if (finish && !lcd_done) finish_early++;
      if (finish && finish_cyc < 0) finish_cyc = cyc;
      prev_valid = cmd_valid;
      prev_busy  = lcd_busy;
      prev_a     = crom_a;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset(input int init_busy);
    @(negedge clk);
    reset = 1'b1; crom_q = '0; lcd_done = 1'b0; write_seen = 0; busy_left = 0; lcd_busy = 1'b1;
    @(negedge clk);
    check_eq("rst_crom_en", crom_en, 0);
    check_eq("rst_crom_a", crom_a, 0);
    check_eq("rst_cmd", cmd, 0);
    check_eq("rst_cmd_valid", cmd_valid, 0);
    check_eq("rst_cmd_cnt", cmd_cnt, 0);
    check_eq("rst_finish", finish, 0);
`ifdef CMD_SEQ_WDT_EN
    check_eq("rst_err", err, 0);
`endif
    clear_mon();
    busy_left = init_busy;
    lcd_busy  = 1'b1;
    reset     = 1'b0;
  endtask

  task automatic wait_finish(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (finish) break;
      @(negedge clk);
    end
    check_eq(tag, finish, 1);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 32; i++) rom[i] = {1'b1, CMD_AVG};
    rom[0] = {1'b1, CMD_UP};
    rom[1] = {1'b1, CMD_RIGHT};
    rom[2] = {1'b1, CMD_WRITE};
  endtask

  task automatic check_seq3(input string tag, input logic [2:0] c0, input logic [2:0] c1);
    check_eq({tag, "_nstrobe"}, strobes.size(), 3);
    if (strobes.size() == 3) begin
      check_eq({tag, "_cmd0"}, strobes[0], c0);
      check_eq({tag, "_cmd1"}, strobes[1], c1);
      check_eq({tag, "_cmd2"}, strobes[2], CMD_WRITE);
    end
    check_eq({tag, "_cmd_cnt"}, cmd_cnt, 3);
    check_eq({tag, "_fetch3"}, fetch_mask[3], 0);
    check_eq({tag, "_busy_strobe"}, bad_busy, 0);
    check_eq({tag, "_double"}, dbl, 0);
    check_eq({tag, "_cmd_hold"}, cmd_glitch, 0);
    check_eq({tag, "_finish_early"}, finish_early, 0);
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [2:0] exp_op;
    reset = 1'b1; lcd_busy = 1'b1; lcd_done = 1'b0; crom_q = '0;
    clear_mon();

    // T1: up, right, write; controller busy 64 cycles after reset
    load_basic();
    hold = 2;
    do_reset(64);
    wait_finish("t1_finish", 2000);
    check_seq3("t1", CMD_UP, CMD_RIGHT);
    foreach (lat_q[i]) check_eq("t1_latency", lat_q[i], 3);
    repeat (5) @(negedge clk);
    check_eq("t1_finish_held", finish, 1);
    check_eq("t1_no_strobe_after", strobes.size(), 3);

    // T2: entry 2 is an end marker carrying a non-write opcode
    load_basic();
    rom[1] = {1'b1, CMD_LEFT};
    rom[2] = {1'b0, CMD_AVG};
    rom[3] = {1'b1, CMD_DOWN};
    do_reset(4);
    wait_finish("t2_finish", 2000);
    check_seq3("t2", CMD_UP, CMD_LEFT);

    // T3: 32 valid non-write entries -> synthetic write after entry 31
    for (int i = 0; i < 32; i++) rom[i] = {1'b1, 3'((i % 7) + 1)};
    hold = 1;
    do_reset(4);
    wait_finish("t3_finish", 3000);
    check_eq("t3_nstrobe", strobes.size(), 33);
    if (strobes.size() == 33) begin
      for (int i = 0; i < 32; i++) begin
        exp_op = 3'((i % 7) + 1);
        check_eq($sformatf("t3_cmd%0d", i), strobes[i], exp_op);
      end
      check_eq("t3_synth_write", strobes[32], CMD_WRITE);
    end
    check_eq("t3_cmd_cnt", cmd_cnt, 33);
    check_eq("t3_wrap", wrap, 0);
    check_eq("t3_crom_a_end", crom_a, 31);
    check_eq("t3_double", dbl, 0);

    // T4: controller busy 10 extra cycles per command
    load_basic();
    hold = 12;
    do_reset(4);
    wait_finish("t4_finish", 2000);
    check_seq3("t4", CMD_UP, CMD_RIGHT);
    foreach (lat_q[i]) check_eq("t4_latency", lat_q[i], 3);
    if (strobe_cyc.size() == 3) check_eq("t4_gap", strobe_cyc[1] - strobe_cyc[0], 12 + 1 + 3);

    // T5: asynchronous reset while in WAIT_IDLE, then restart
    load_basic();
    hold = 8;
    do_reset(4);
    for (int i = 0; i < 500; i++) begin
      if (cmd_cnt == 6'd2) break;
      @(negedge clk);
    end
    check_eq("t5_reach_cnt2", cmd_cnt, 2);
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_pre_a", crom_a, 1);
    check_eq("t5_pre_busy", lcd_busy, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_async_crom_a", crom_a, 0);
    check_eq("t5_async_cmd", cmd, 0);
    check_eq("t5_async_cmd_cnt", cmd_cnt, 0);
    check_eq("t5_async_valid", cmd_valid, 0);
    check_eq("t5_async_en", crom_en, 0);
    check_eq("t5_async_finish", finish, 0);
    @(negedge clk);
    clear_mon();
    lcd_done = 1'b0; write_seen = 0; busy_left = 6; lcd_busy = 1'b1;
    reset = 1'b0;
    wait_finish("t5_finish", 2000);
    check_eq("t5_first_fetch", first_fetch, 0);
    check_seq3("t5", CMD_UP, CMD_RIGHT);

`ifdef CMD_SEQ_WDT_EN
    // T6: controller never acknowledges -> watchdog
    load_basic();
    hold = 2;
    ack_en = 0;
    do_reset(4);
    for (int i = 0; i < 200; i++) begin
      if (strobes.size() > 0) break;
      @(negedge clk);
    end
    check_eq("t6_strobe_seen", strobes.size() > 0, 1);
    wait_finish("t6_finish", 200);
    check_eq("t6_err", err, 1);
    if (strobe_cyc.size() > 0) check_eq("t6_wdt_latency", finish_cyc - strobe_cyc[0], 21);
    ack_en = 1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
